// File: rtl/mig_app_responder.sv
// mig_app_responder: on-chip RAM stand-in for the MIG app_* user interface.
// Commands and write data are queued, executed in order, and reads return after a fixed latency.
//
// state    | meaning
// ST_CALIB | calibration counter running; app_rdy and app_wdf_rdy held low
// ST_RUN   | calibrated; commands and write data accepted and executed
module mig_app_responder #(
   parameter int ADDR_WIDTH   = 28,
   parameter int DATA_WIDTH   = 128,
   parameter int MASK_WIDTH   = 16,
   parameter int DEPTH_LOG2   = 10,
   parameter int CMD_DEPTH    = 4,
   parameter int WDF_DEPTH    = 4,
   parameter int RD_LATENCY   = 4,
   parameter int CALIB_CYCLES = 16,
   parameter int STALL_PERIOD = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  app_en,
   input  logic [2:0]            app_cmd,
   input  logic [ADDR_WIDTH-1:0] app_addr,
   output logic                  app_rdy,
   input  logic                  app_wdf_wren,
   input  logic [DATA_WIDTH-1:0] app_wdf_data,
   input  logic [MASK_WIDTH-1:0] app_wdf_mask,
   input  logic                  app_wdf_end,
   output logic                  app_wdf_rdy,
   output logic [DATA_WIDTH-1:0] app_rd_data,
   output logic                  app_rd_data_valid,
   output logic                  app_rd_data_end,
   output logic                  init_calib_complete,
   output logic                  err_bad_cmd,
   output logic [63:0]           cmd_count
);

   localparam int CMD_AW    = $clog2(CMD_DEPTH);
   localparam int WDF_AW    = $clog2(WDF_DEPTH);
   localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
   localparam int RAM_WORDS = 2 ** DEPTH_LOG2;

   localparam logic [2:0]       CMD_WR   = 3'b000;
   localparam logic [2:0]       CMD_RD   = 3'b001;
   localparam logic [CMD_AW:0]  CMD_ONE  = 1;
   localparam logic [WDF_AW:0]  WDF_ONE  = 1;
   localparam logic [CAL_W-1:0] CAL_ONE  = 1;
   localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);

   typedef enum logic {
      ST_CALIB = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CAL_W-1:0] calib_cnt_q, calib_cnt_d;
   logic             stall;

   logic [2:0]            cmd_mem_cmd [CMD_DEPTH];
   logic [DEPTH_LOG2-1:0] cmd_mem_idx [CMD_DEPTH];
   logic [CMD_AW:0]       cmd_wp, cmd_rp;
   logic                  cmd_empty, cmd_full, cmd_push, cmd_pop;
   logic [2:0]            head_cmd;
   logic [DEPTH_LOG2-1:0] head_idx;

   logic [DATA_WIDTH-1:0] wdf_mem_data [WDF_DEPTH];
   logic [MASK_WIDTH-1:0] wdf_mem_mask [WDF_DEPTH];
   logic [WDF_AW:0]       wdf_wp, wdf_rp;
   logic                  wdf_empty, wdf_full, wdf_push, wdf_pop;
   logic [DATA_WIDTH-1:0] wdf_head_data;
   logic [MASK_WIDTH-1:0] wdf_head_mask;

   logic exec_rd, exec_wr, exec_bad;

   logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
   logic [RD_LATENCY-1:0] rd_vld_pipe;
   logic [DATA_WIDTH-1:0] rd_data_pipe [RD_LATENCY];

   // Only the RAM index bits matter; app_wdf_end always mirrors app_wdf_wren for single-beat BL8.
   logic unused_bits;
   assign unused_bits = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CALIB;
         calib_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         calib_cnt_q <= calib_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      calib_cnt_d = calib_cnt_q;
      case (state_q)
         ST_CALIB: begin
            calib_cnt_d = calib_cnt_q + CAL_ONE;
            if (calib_cnt_q == CAL_LAST) state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         logic [31:0] stall_cnt_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                                    stall_cnt_q <= '0;
            else if (state_q != ST_RUN)                 stall_cnt_q <= '0;
            else if (stall_cnt_q == 32'(STALL_PERIOD - 1)) stall_cnt_q <= '0;
            else                                        stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         assign stall = (state_q == ST_RUN) && (stall_cnt_q == 32'(STALL_PERIOD - 1));
      end else begin : g_no_stall
         assign stall = 1'b0;
      end
   endgenerate

   assign cmd_empty = (cmd_wp == cmd_rp);
   assign cmd_full  = (cmd_wp[CMD_AW] != cmd_rp[CMD_AW]) &&
                      (cmd_wp[CMD_AW-1:0] == cmd_rp[CMD_AW-1:0]);
   assign wdf_empty = (wdf_wp == wdf_rp);
   assign wdf_full  = (wdf_wp[WDF_AW] != wdf_rp[WDF_AW]) &&
                      (wdf_wp[WDF_AW-1:0] == wdf_rp[WDF_AW-1:0]);

   assign app_rdy             = (state_q == ST_RUN) && !cmd_full && !stall;
   assign app_wdf_rdy         = (state_q == ST_RUN) && !wdf_full;
   assign init_calib_complete = (state_q == ST_RUN);

   assign cmd_push = app_en && app_rdy;
   assign wdf_push = app_wdf_wren && app_wdf_rdy;

   assign head_cmd      = cmd_mem_cmd[cmd_rp[CMD_AW-1:0]];
   assign head_idx      = cmd_mem_idx[cmd_rp[CMD_AW-1:0]];
   assign wdf_head_data = wdf_mem_data[wdf_rp[WDF_AW-1:0]];
   assign wdf_head_mask = wdf_mem_mask[wdf_rp[WDF_AW-1:0]];

   // A write at the head waits for its data beat; reads and illegal commands never wait.
   always_comb begin
      exec_rd  = 1'b0;
      exec_wr  = 1'b0;
      exec_bad = 1'b0;
      if (!cmd_empty) begin
         if (head_cmd == CMD_RD)      exec_rd  = 1'b1;
         else if (head_cmd == CMD_WR) exec_wr  = !wdf_empty;
         else                         exec_bad = 1'b1;
      end
   end

   assign cmd_pop = exec_rd || exec_wr || exec_bad;
   assign wdf_pop = exec_wr;

   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_mem_cmd[cmd_wp[CMD_AW-1:0]] <= app_cmd;
         cmd_mem_idx[cmd_wp[CMD_AW-1:0]] <= app_addr[DEPTH_LOG2+2:3];
      end
      if (wdf_push) begin
         wdf_mem_data[wdf_wp[WDF_AW-1:0]] <= app_wdf_data;
         wdf_mem_mask[wdf_wp[WDF_AW-1:0]] <= app_wdf_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_wp      <= '0;
         cmd_rp      <= '0;
         wdf_wp      <= '0;
         wdf_rp      <= '0;
         cmd_count   <= '0;
         err_bad_cmd <= 1'b0;
      end else begin
         if (cmd_push) cmd_wp <= cmd_wp + CMD_ONE;
         if (cmd_pop)  cmd_rp <= cmd_rp + CMD_ONE;
         if (wdf_push) wdf_wp <= wdf_wp + WDF_ONE;
         if (wdf_pop)  wdf_rp <= wdf_rp + WDF_ONE;
         if (cmd_pop)  cmd_count <= cmd_count + 64'd1;
         if (exec_bad) err_bad_cmd <= 1'b1;
      end
   end

   // RAM contents survive reset; a masked bit of 1 leaves that byte untouched.
   always_ff @(posedge clk) begin
      if (exec_wr) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (!wdf_head_mask[b]) mem[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (exec_rd) rd_data_pipe[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) rd_data_pipe[i] <= rd_data_pipe[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_pipe <= '0;
      end else begin
         rd_vld_pipe[0] <= exec_rd;
         for (int i = 1; i < RD_LATENCY; i++) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
      end
   end

   assign app_rd_data_valid = rd_vld_pipe[RD_LATENCY-1];
   assign app_rd_data_end   = app_rd_data_valid;
   assign app_rd_data       = app_rd_data_valid ? rd_data_pipe[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: calibration, masked writes, ordering, backpressure,
// illegal commands and mid-operation reset, all against hand-computed expectations.
module tb_mig_app_responder;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = 16;
   localparam int LAT = 4;
   localparam logic [2:0] WR = 3'b000;
   localparam logic [2:0] RD = 3'b001;
   localparam logic [DW-1:0] D_BEEF = 128'h0123456789abcdef_00112233_deadbeef;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          app_en = 1'b0;
   logic [2:0]    app_cmd = '0;
   logic [AW-1:0] app_addr = '0;
   logic          app_rdy;
   logic          app_wdf_wren = 1'b0;
   logic [DW-1:0] app_wdf_data = '0;
   logic [MW-1:0] app_wdf_mask = '0;
   logic          app_wdf_end = 1'b0;
   logic          app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          app_rd_data_end;
   logic          init_calib_complete;
   logic          err_bad_cmd;
   logic [63:0]   cmd_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int exp_cnt = 0;
   int end_bad = 0;
   int last_acc = 0;
   logic [DW-1:0] rdq[$];
   int            rcq[$];

   mig_app_responder dut (
      .clk                 (clk),
      .rst                 (rst),
      .app_en              (app_en),
      .app_cmd             (app_cmd),
      .app_addr            (app_addr),
      .app_rdy             (app_rdy),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .init_calib_complete (init_calib_complete),
      .err_bad_cmd         (err_bad_cmd),
      .cmd_count           (cmd_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // cyc at a negedge equals the number of rising edges so far
   always @(negedge clk) begin
      if (app_rd_data_end !== app_rd_data_valid) end_bad++;
      if (app_rd_data_valid) begin
         rdq.push_back(app_rd_data);
         rcq.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int i);
      return {4{32'hc0de0000 + 32'(i)}};
   endfunction

   task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
      int n;
      @(negedge clk);
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      app_en   = 1'b1;
      app_cmd  = c;
      app_addr = a;
      n = 0;
      while (!app_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept", (n < 100), 1);
      last_acc = cyc + 1;
      exp_cnt++;
   endtask

   task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
      int n;
      @(negedge clk);
      app_en       = 1'b0;
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
      app_wdf_data = d;
      app_wdf_mask = m;
      n = 0;
      while (!app_wdf_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("data_accept", (n < 100), 1);
   endtask

   task automatic idle();
      @(negedge clk);
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
   endtask

   task automatic wait_rd(input string tag, input logic [DW-1:0] exp_d, input int exp_c, input bit chk_c);
      int n;
      logic [DW-1:0] d;
      int c;
      n = 0;
      while (rdq.size() == 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (rdq.size() == 0) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         d = rdq.pop_front();
         c = rcq.pop_front();
         check({tag, "_data"}, d, exp_d);
         if (chk_c) check({tag, "_cycle"}, c, exp_c);
      end
   endtask

   task automatic calib_walk(input string tag, input bit every);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (every || k >= 15) begin
            check({tag, "_init"}, init_calib_complete, (k == 16));
            check({tag, "_rdy"}, app_rdy, (k == 16));
            check({tag, "_wdf_rdy"}, app_wdf_rdy, (k == 16));
         end
      end
   endtask

   initial begin
      int acc;
      int n_acc;
      logic [AW-1:0] a;

      repeat (3) @(negedge clk);
      check("rst_rdy", app_rdy, 0);
      check("rst_wdf_rdy", app_wdf_rdy, 0);
      check("rst_init", init_calib_complete, 0);
      check("rst_err", err_bad_cmd, 0);
      check("rst_count", cmd_count, 0);
      check("rst_valid", app_rd_data_valid, 0);
      rst = 1'b0;
      calib_walk("calib", 1'b1);

      send_data(D_BEEF, '0);
      send_cmd(WR, 28'h40);
      send_cmd(RD, 28'h40);
      acc = last_acc;
      idle();
      wait_rd("raw", D_BEEF, acc + LAT, 1'b1);

      send_data('1, '0);
      send_cmd(WR, 28'h80);
      send_data('0, 16'hfffe);
      send_cmd(WR, 28'h80);
      send_cmd(RD, 28'h80);
      acc = last_acc;
      idle();
      wait_rd("mask", {{120{1'b1}}, 8'h00}, acc + LAT, 1'b1);
      send_cmd(RD, 28'h2085);
      idle();
      wait_rd("alias", {{120{1'b1}}, 8'h00}, 0, 1'b0);

      for (int i = 0; i < 4; i++) send_data(pat(i), '0);
      for (int i = 0; i < 4; i++) begin
         a = 28'h100 + 28'(i * 8);
         send_cmd(WR, a);
      end
      for (int i = 0; i < 4; i++) begin
         a = 28'h100 + 28'(i * 8);
         send_cmd(RD, a);
         if (i == 0) acc = last_acc;
      end
      idle();
      for (int i = 0; i < 4; i++) wait_rd("burst", pat(i), acc + LAT + i, 1'b1);

      @(negedge clk);
      app_wdf_wren = 1'b0;
      app_en   = 1'b1;
      app_cmd  = WR;
      app_addr = 28'h200;
      n_acc = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (app_rdy) n_acc++;
      end
      check("hold_accepts", n_acc, 4);
      check("hold_rdy_low", app_rdy, 0);
      exp_cnt += 4;
      idle();
      for (int i = 0; i < 4; i++) send_data(pat(10 + i), '0);
      idle();
      repeat (3) @(negedge clk);
      check("drain_count", cmd_count, exp_cnt);
      check("drain_rdy", app_rdy, 1);
      send_cmd(RD, 28'h200);
      idle();
      wait_rd("drain_last", pat(13), 0, 1'b0);

      check("err_before", err_bad_cmd, 0);
      send_cmd(3'b011, 28'h0);
      idle();
      repeat (2) @(negedge clk);
      check("bad_err", err_bad_cmd, 1);
      check("bad_count", cmd_count, exp_cnt);
      send_cmd(RD, 28'h40);
      idle();
      wait_rd("after_bad", D_BEEF, 0, 1'b0);
      check("bad_sticky", err_bad_cmd, 1);

      check("pre_rst_queue", rdq.size(), 0);
      send_cmd(RD, 28'h40);
      send_cmd(RD, 28'h80);
      @(negedge clk);
      rst = 1'b1;
      app_en = 1'b0;
      #1;
      check("mid_rst_valid", app_rd_data_valid, 0);
      check("mid_rst_init", init_calib_complete, 0);
      check("mid_rst_count", cmd_count, 0);
      check("mid_rst_err", err_bad_cmd, 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      calib_walk("recal", 1'b0);
      check("no_valid_after_rst", rdq.size(), 0);

      send_cmd(RD, 28'h40);
      acc = last_acc;
      idle();
      wait_rd("ram_kept", D_BEEF, acc + LAT, 1'b1);
      check("final_count", cmd_count, exp_cnt);
      check("rd_end_tracks_valid", end_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
